// File: rtl/adder_pkg.sv
// adder_pkg: shared state type and nibble width for the nibble-serial adder
package adder_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} nsa_state_t;
    localparam int NIBBLE_W = 4;
endpackage

// File: rtl/rca.sv
// rca: 4-bit ripple-carry adder
module rca (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       c4_o
);
    logic [4:0] c;
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = ci_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        c4_o = c[4];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/sub using one 4-bit rca, one nibble per clock, LSB first
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    nsa_state_t        state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [NIBBLE_W-1:0] nib_s;
    logic              nib_c, last;

    rca u_rca (
        .a_i  (op_a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
        .b_i  (op_b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
        .ci_i (carry_q),
        .s_o  (nib_s),
        .c4_o (nib_c)
    );

    assign last      = idx_q == IW'(NIB - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            op_a_d  = a;
            op_b_d  = sub ? ~b : b;
            carry_d = sub;
            idx_d   = '0;
            state_d = BUSY;
        end
        if (state_q == BUSY) begin
            sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_s;
            carry_d = nib_c;
            idx_d   = idx_q + 1'b1;
            // nib_s[MSB] of the last nibble is the result sign bit
            if (last) begin
                state_d = DONE;
                cout_d  = nib_c;
                ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (nib_s[NIBBLE_W-1] != op_a_q[WIDTH-1]);
            end
        end
        if (state_q == DONE && out_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
